// File: rtl/sram_23lc1024_responder_pkg.sv
// Shared constants and types for the 23LC1024 SPI SRAM responder.
// Holds the opcode set and mode-register default common with the master side,
// plus the responder FSM state and per-frame operation encodings.
package sram_23lc1024_responder_pkg;

  localparam logic [7:0] OPCODE_WRITE     = 8'h02;
  localparam logic [7:0] OPCODE_READ      = 8'h03;
  localparam logic [7:0] OPCODE_RDMR      = 8'h05;
  localparam logic [7:0] OPCODE_WRMR      = 8'h01;
  localparam logic [7:0] MODE_REG_DEFAULT = 8'h40;

  localparam int unsigned CMD_BITS  = 8;
  localparam int unsigned ADDR_BITS = 24;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_RD_DATA,
    ST_WR_DATA,
    ST_MODE_RD,
    ST_MODE_WR,
    ST_IGNORE
  } state_t;

  typedef enum logic {
    OP_READ,
    OP_WRITE
  } op_t;

endpackage

// File: rtl/spi_pin_sync.sv
// Two-flop synchronizer for one SPI pin with one-clk rise/fall strobes.
// Ports:
//   i_clk, i_rst_n : system clock, async active-low reset
//   i_pin          : asynchronous pin input
//   o_sync         : synchronized level
//   o_rise/o_fall  : one-clk strobes, aligned with the o_sync transition
module spi_pin_sync #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_pin,
  output logic o_sync,
  output logic o_rise,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_rise;
  logic r_fall;

  // Strobes are computed from the flop pair so they land with the new level.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_meta <= i_pin;
      r_sync <= r_meta;
      r_rise <= r_meta & ~r_sync;
      r_fall <= ~r_meta & r_sync;
    end
  end

  assign o_sync = r_sync;
  assign o_rise = r_rise;
  assign o_fall = r_fall;

endmodule

// File: rtl/sram_23lc1024_responder.sv
// SPI-slave model of the 23LC1024 serial SRAM (mode 0), oversampled on clk.
// Decodes READ/WRITE/RDMR/WRMR frames and backs them with a byte array.
// Ports:
//   clk, rst_n : system clock, async active-low reset
//   CSn        : chip select, active low
//   SCK        : serial clock (mode 0)
//   SI         : serial data in, sampled on SCK rise
//   SO         : serial data out, changed on SCK fall
//   SO_oe      : SO pad enable, high only while shifting read data
//   busy       : high while a frame is in progress
module sram_23lc1024_responder
  import sram_23lc1024_responder_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter logic [7:0]  MODE_REG   = MODE_REG_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic CSn,
  input  logic SCK,
  input  logic SI,
  output logic SO,
  output logic SO_oe,
  output logic busy
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  // Only the bits that survive address truncation are kept; ADDR_WIDTH >= 8
  // so the same shifter also holds the opcode.
  localparam int unsigned SH_W  = ADDR_WIDTH - 1;

  logic w_cs_sync, w_cs_rise, w_cs_fall;
  logic w_sck_sync, w_sck_rise, w_sck_fall;
  logic w_si, w_si_rise, w_si_fall;
  logic w_unused_sync;

  spi_pin_sync #(.RESET_VAL(1'b1)) u_cs_sync (
    .i_clk(clk), .i_rst_n(rst_n), .i_pin(CSn),
    .o_sync(w_cs_sync), .o_rise(w_cs_rise), .o_fall(w_cs_fall)
  );

  spi_pin_sync #(.RESET_VAL(1'b0)) u_sck_sync (
    .i_clk(clk), .i_rst_n(rst_n), .i_pin(SCK),
    .o_sync(w_sck_sync), .o_rise(w_sck_rise), .o_fall(w_sck_fall)
  );

  spi_pin_sync #(.RESET_VAL(1'b0)) u_si_sync (
    .i_clk(clk), .i_rst_n(rst_n), .i_pin(SI),
    .o_sync(w_si), .o_rise(w_si_rise), .o_fall(w_si_fall)
  );

  assign w_unused_sync = w_sck_sync ^ w_si_rise ^ w_si_fall;

  state_t                r_state;
  op_t                   r_op;
  logic [4:0]            r_bit_cnt;
  logic [SH_W-1:0]       r_shift;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [7:0]            r_tx;
  logic [7:0]            r_wr_byte;
  logic                  r_load;
  logic                  r_so;
  logic                  r_oe;
  logic                  r_busy;
  logic                  r_armed;
  logic [1:0]            r_arm_cnt;

  logic [7:0]            r_mem [DEPTH];
  logic [7:0]            r_mem_q;

  logic                  w_mem_re;
  logic                  w_mem_we;
  logic [ADDR_WIDTH-1:0] w_mem_addr;
  logic [7:0]            w_mem_wdata;
  logic [7:0]            w_opcode;

  assign w_opcode = {r_shift[6:0], w_si};

  // Array port control: address-phase read, prefetch on byte end, write commit.
  always_comb begin
    w_mem_re    = 1'b0;
    w_mem_we    = 1'b0;
    w_mem_addr  = r_addr;
    w_mem_wdata = {r_wr_byte[6:0], w_si};
    if (!w_cs_rise) begin
      case (r_state)
        ST_ADDR: begin
          if (w_sck_rise && r_bit_cnt == 5'd23 && r_op == OP_READ) begin
            w_mem_re   = 1'b1;
            w_mem_addr = {r_shift, w_si};
          end
        end
        ST_RD_DATA: begin
          if (w_sck_fall && r_bit_cnt == 5'd7) begin
            w_mem_re   = 1'b1;
            w_mem_addr = r_addr + ADDR_WIDTH'(1);
          end
        end
        ST_WR_DATA: begin
          if (w_sck_rise && r_bit_cnt == 5'd7) w_mem_we = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Single-port synchronous RAM, intentionally not reset.
  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[w_mem_addr] <= w_mem_wdata;
    if (w_mem_re) r_mem_q <= r_mem[w_mem_addr];
  end

  // Frame FSM. r_armed blocks the spurious CSn fall that the synchronizer
  // sees when rst_n releases while CSn is still low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_op      <= OP_READ;
      r_bit_cnt <= 5'd0;
      r_shift   <= '0;
      r_addr    <= '0;
      r_tx      <= 8'h00;
      r_wr_byte <= 8'h00;
      r_load    <= 1'b0;
      r_so      <= 1'b0;
      r_oe      <= 1'b0;
      r_busy    <= 1'b0;
      r_armed   <= 1'b0;
      r_arm_cnt <= 2'd0;
    end else begin
      if (!r_armed) begin
        if (r_arm_cnt == 2'd3) r_armed <= 1'b1;
        r_arm_cnt <= w_cs_sync ? ((r_arm_cnt == 2'd3) ? 2'd3 : r_arm_cnt + 2'd1) : 2'd0;
      end

      r_load <= w_mem_re;
      if (r_load) r_tx <= r_mem_q;

      if (w_cs_rise) begin
        r_state   <= ST_IDLE;
        r_bit_cnt <= 5'd0;
        r_wr_byte <= 8'h00;
        r_load    <= 1'b0;
        r_so      <= 1'b0;
        r_oe      <= 1'b0;
        r_busy    <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_cs_fall && r_armed) begin
              r_state   <= ST_CMD;
              r_bit_cnt <= 5'd0;
              r_shift   <= '0;
              r_busy    <= 1'b1;
            end
          end
          ST_CMD: begin
            if (w_sck_rise) begin
              r_shift   <= {r_shift[SH_W-2:0], w_si};
              r_bit_cnt <= r_bit_cnt + 5'd1;
              if (r_bit_cnt == 5'(CMD_BITS - 1)) begin
                r_bit_cnt <= 5'd0;
                case (w_opcode)
                  OPCODE_READ:  begin r_op <= OP_READ;  r_state <= ST_ADDR; end
                  OPCODE_WRITE: begin r_op <= OP_WRITE; r_state <= ST_ADDR; end
                  OPCODE_RDMR:  begin r_tx <= MODE_REG; r_state <= ST_MODE_RD; end
                  OPCODE_WRMR:  r_state <= ST_MODE_WR;
                  default:      r_state <= ST_IGNORE;
                endcase
              end
            end
          end
          ST_ADDR: begin
            if (w_sck_rise) begin
              r_shift   <= {r_shift[SH_W-2:0], w_si};
              r_bit_cnt <= r_bit_cnt + 5'd1;
              if (r_bit_cnt == 5'(ADDR_BITS - 1)) begin
                r_bit_cnt <= 5'd0;
                r_addr    <= {r_shift, w_si};
                r_state   <= (r_op == OP_READ) ? ST_RD_DATA : ST_WR_DATA;
              end
            end
          end
          ST_RD_DATA: begin
            if (w_sck_fall) begin
              r_so      <= r_tx[7];
              r_oe      <= 1'b1;
              r_tx      <= {r_tx[6:0], 1'b0};
              r_bit_cnt <= r_bit_cnt + 5'd1;
              if (r_bit_cnt == 5'd7) begin
                r_bit_cnt <= 5'd0;
                r_addr    <= r_addr + ADDR_WIDTH'(1);
              end
            end
          end
          ST_WR_DATA: begin
            if (w_sck_rise) begin
              r_wr_byte <= w_mem_wdata;
              r_bit_cnt <= r_bit_cnt + 5'd1;
              if (r_bit_cnt == 5'd7) begin
                r_bit_cnt <= 5'd0;
                r_addr    <= r_addr + ADDR_WIDTH'(1);
              end
            end
          end
          ST_MODE_RD: begin
            if (w_sck_fall) begin
              r_so      <= r_tx[7];
              r_oe      <= 1'b1;
              r_tx      <= {r_tx[6:0], 1'b0};
              r_bit_cnt <= r_bit_cnt + 5'd1;
              if (r_bit_cnt == 5'd7) begin
                r_bit_cnt <= 5'd0;
                r_tx      <= MODE_REG;
              end
            end
          end
          ST_MODE_WR: begin
            // Mode is fixed: the written value is consumed and dropped.
            if (w_sck_rise) begin
              r_bit_cnt <= r_bit_cnt + 5'd1;
              if (r_bit_cnt == 5'd7) begin
                r_bit_cnt <= 5'd0;
                r_state   <= ST_IGNORE;
              end
            end
          end
          ST_IGNORE: ;
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign SO    = r_so;
  assign SO_oe = r_oe;
  assign busy  = r_busy;

endmodule

// File: tb/tb_sram_23lc1024_responder.sv
// Scoreboard bench for sram_23lc1024_responder: a driver acts as the SPI master
// and pushes expected read bytes; a monitor samples SO on SCK rise (as a mode-0
// master would), checks SO_oe against the current phase and pops/compares bytes.
module tb_sram_23lc1024_responder;

  localparam int HALF = 6;

  logic clk;
  logic rst_n;
  logic CSn;
  logic SCK;
  logic SI;
  logic SO;
  logic SO_oe;
  logic busy;

  int total;
  int bad;

  logic [7:0] exp_q [$];
  logic       exp_oe;
  logic [7:0] mon_byte;
  int         mon_nbits;

  sram_23lc1024_responder #(.ADDR_WIDTH(10), .MODE_REG(8'h40)) dut (
    .clk(clk), .rst_n(rst_n), .CSn(CSn), .SCK(SCK), .SI(SI),
    .SO(SO), .SO_oe(SO_oe), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, act, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_bit(input logic b, input logic oe);
    SI     = b;
    exp_oe = oe;
    tick(HALF);
    SCK = 1'b1;
    tick(HALF);
    SCK = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic oe);
    for (int i = 7; i >= 0; i--) spi_bit(b[i], oe);
  endtask

  task automatic frame_begin();
    CSn = 1'b0;
    tick(6);
  endtask

  task automatic frame_end();
    tick(HALF);
    CSn    = 1'b1;
    exp_oe = 1'b0;
    tick(12);
  endtask

  task automatic send_addr(input logic [23:0] a);
    send_byte(a[23:16], 1'b0);
    send_byte(a[15:8], 1'b0);
    send_byte(a[7:0], 1'b0);
  endtask

  task automatic wr_frame(input logic [23:0] a, input logic [7:0] d0,
                          input logic [7:0] d1, input logic [7:0] d2, input int n);
    logic [7:0] d [3];
    d[0] = d0; d[1] = d1; d[2] = d2;
    frame_begin();
    chk("busy_in_wr_frame", {31'd0, busy}, 32'd1);
    send_byte(8'h02, 1'b0);
    send_addr(a);
    for (int k = 0; k < n; k++) send_byte(d[k], 1'b0);
    frame_end();
    chk("busy_after_wr_frame", {31'd0, busy}, 32'd0);
  endtask

  task automatic rd_frame(input logic [23:0] a, input logic [7:0] e0,
                          input logic [7:0] e1, input logic [7:0] e2, input int n);
    logic [7:0] e [3];
    e[0] = e0; e[1] = e1; e[2] = e2;
    frame_begin();
    chk("busy_in_rd_frame", {31'd0, busy}, 32'd1);
    send_byte(8'h03, 1'b0);
    send_addr(a);
    for (int k = 0; k < n; k++) begin
      exp_q.push_back(e[k]);
      send_byte(8'h00, 1'b1);
    end
    frame_end();
    chk("busy_after_rd_frame", {31'd0, busy}, 32'd0);
  endtask

  // Monitor: SCK pin rises on a clk negedge, well away from the active edge.
  always @(posedge SCK or posedge CSn or negedge rst_n) begin
    if (!rst_n || CSn) begin
      mon_nbits = 0;
    end else begin
      chk("so_oe_phase", {31'd0, SO_oe}, {31'd0, exp_oe});
      if (SO_oe) begin
        mon_byte  = {mon_byte[6:0], SO};
        mon_nbits = mon_nbits + 1;
        if (mon_nbits == 8) begin
          mon_nbits = 0;
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL rd_unexpected: got=%0h want=none", mon_byte);
          end else begin
            chk("rd_byte", {24'd0, mon_byte}, {24'd0, exp_q.pop_front()});
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got=running want=finished");
    $fatal(1, "timeout");
  end

  initial begin
    total     = 0;
    bad       = 0;
    mon_nbits = 0;
    mon_byte  = 8'h00;
    exp_oe    = 1'b0;
    rst_n     = 1'b0;
    CSn       = 1'b1;
    SCK       = 1'b0;
    SI        = 1'b0;
    tick(5);
    chk("rst_so", {31'd0, SO}, 32'd0);
    chk("rst_so_oe", {31'd0, SO_oe}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    tick(8);

    // Write then read back one byte; also address truncation of 0x010410.
    wr_frame(24'h000010, 8'hA5, 8'h00, 8'h00, 1);
    rd_frame(24'h000010, 8'hA5, 8'h00, 8'h00, 1);
    rd_frame(24'h010410, 8'hA5, 8'h00, 8'h00, 1);

    // Sequential write across the top of the 1 KiB array.
    wr_frame(24'h0003FF, 8'h11, 8'h22, 8'h33, 3);
    rd_frame(24'h0003FF, 8'h11, 8'h22, 8'h33, 3);
    rd_frame(24'h000000, 8'h22, 8'h33, 8'h00, 2);

    // Mode register read, repeated while CSn stays low.
    frame_begin();
    send_byte(8'h05, 1'b0);
    exp_q.push_back(8'h40);
    send_byte(8'h00, 1'b1);
    exp_q.push_back(8'h40);
    send_byte(8'h00, 1'b1);
    frame_end();

    // Mode write is ignored.
    frame_begin();
    send_byte(8'h01, 1'b0);
    send_byte(8'h00, 1'b0);
    frame_end();
    frame_begin();
    send_byte(8'h05, 1'b0);
    exp_q.push_back(8'h40);
    send_byte(8'h00, 1'b1);
    frame_end();

    // Illegal opcode: SO_oe stays low for 32 more clocks.
    frame_begin();
    send_byte(8'h9F, 1'b0);
    for (int k = 0; k < 4; k++) send_byte(8'hFF, 1'b0);
    frame_end();

    // Partial write byte is dropped on CSn rise.
    wr_frame(24'h000020, 8'h5A, 8'h00, 8'h00, 1);
    frame_begin();
    send_byte(8'h02, 1'b0);
    send_addr(24'h000020);
    for (int k = 0; k < 4; k++) spi_bit(1'b1, 1'b0);
    frame_end();
    rd_frame(24'h000020, 8'h5A, 8'h00, 8'h00, 1);

    // Reset during the third data bit of a read.
    frame_begin();
    send_byte(8'h03, 1'b0);
    send_addr(24'h000010);
    spi_bit(1'b0, 1'b1);
    spi_bit(1'b0, 1'b1);
    SI     = 1'b0;
    exp_oe = 1'b1;
    tick(3);
    rst_n = 1'b0;
    #1;
    chk("midrst_so", {31'd0, SO}, 32'd0);
    chk("midrst_so_oe", {31'd0, SO_oe}, 32'd0);
    exp_oe = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(1);
    chk("midrst_busy_release", {31'd0, busy}, 32'd0);
    for (int k = 0; k < 5; k++) spi_bit(1'b1, 1'b0);
    chk("midrst_busy_rest_of_frame", {31'd0, busy}, 32'd0);
    frame_end();
    rd_frame(24'h000010, 8'hA5, 8'h00, 8'h00, 1);

    tick(4);
    chk("exp_q_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
